// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - gathers SETS operand triples, starts the MAC, returns its result
// A watchdog converts a MAC that never completes into an error result.

module mac_operand_feeder #(
  parameter int SIZE    = 4,
  parameter int SETS    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE-1:0]          in_a,
  input  logic [SIZE-1:0]          in_b,
  input  logic [SIZE-1:0]          in_c,
  output logic                     mac_valid,
  output logic [SETS*SIZE-1:0]     mac_a,
  output logic [SETS*SIZE-1:0]     mac_b,
  output logic [SETS*SIZE-1:0]     mac_c,
  input  logic                     mac_ready,
  input  logic [2*SIZE+SETS-1:0]   mac_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*SIZE+SETS-1:0]   res_data,
  output logic                     res_err
);

  localparam int RW = 2*SIZE + SETS;
  localparam int VW = SETS*SIZE;
  localparam int IW = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(SETS - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_TO   = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   mac_a_q, mac_a_d;
  logic [VW-1:0]   mac_b_q, mac_b_d;
  logic [VW-1:0]   mac_c_q, mac_c_d;
  logic [RW-1:0]   res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic            wait_first;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_FILL;
      idx_q      <= '0;
      cnt_q      <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_c_q    <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_c_q    <= mac_c_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // The counter is zero only in the first WAIT cycle; it saturates at a nonzero value.
  assign wait_first = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_c_d    = mac_c_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          mac_a_d[idx_q*SIZE +: SIZE] = in_a;
          mac_b_d[idx_q*SIZE +: SIZE] = in_b;
          mac_c_d[idx_q*SIZE +: SIZE] = in_c;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_FIRE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_FIRE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        // A genuine completion beats a simultaneous watchdog expiry.
        if (!wait_first && mac_ready) begin
          res_data_d = mac_out;
          res_err_d  = 1'b0;
          state_d    = S_HOLD;
        end else if ((TIMEOUT != 0) && (cnt_d == CNT_TO)) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_err_d = 1'b0;
          state_d   = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  assign in_ready  = (state_q == S_FILL);
  assign mac_valid = (state_q == S_FIRE);
  assign res_valid = (state_q == S_HOLD);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = mac_c_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - checks the feeder against a behavioural MAC stub and reference sums
// Stub modes: 0 ready after a latency, 1 never ready, 2 ready stuck high with stale data first.

module tb_mac_operand_feeder;

  localparam int SIZE    = 4;
  localparam int SETS    = 8;
  localparam int TIMEOUT = 16;
  localparam int RW      = 2*SIZE + SETS;
  localparam logic [RW-1:0] STALE = 16'hABCD;

  typedef logic [3:0] vec_t [8];

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_a, in_b, in_c;
  logic            mac_valid;
  logic [31:0]     mac_a, mac_b, mac_c;
  logic            mac_ready;
  logic [RW-1:0]   mac_out;
  logic            res_valid;
  logic            res_ready;
  logic [RW-1:0]   res_data;
  logic            res_err;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;
  int pulses   = 0;
  int stub_mode = 0;
  int stub_lat  = 3;
  logic          stub_busy;
  int            stub_cnt;
  logic [RW-1:0] stub_res;

  always #5 clk = ~clk;

  mac_operand_feeder #(.SIZE(SIZE), .SETS(SETS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_ready(mac_ready), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  function automatic logic [RW-1:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    int s = 0;
    for (int i = 0; i < 8; i++)
      s += int'(a[i*4 +: 4]) * int'(b[i*4 +: 4]) + int'(c[i*4 +: 4]);
    return RW'(s);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_res  <= '0;
    end else if (mac_valid) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 0;
      stub_res  <= mac_fn(mac_a, mac_b, mac_c);
    end else if (stub_busy && stub_cnt < 1000) begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  always_comb begin
    mac_ready = 1'b0;
    mac_out   = STALE;
    case (stub_mode)
      0: begin
        mac_ready = stub_busy && (stub_cnt >= stub_lat);
        mac_out   = mac_ready ? stub_res : STALE;
      end
      1: begin
        mac_ready = 1'b0;
        mac_out   = stub_res;
      end
      default: begin
        mac_ready = 1'b1;
        mac_out   = (stub_busy && stub_cnt >= 1) ? stub_res : STALE;
      end
    endcase
  end

  always @(posedge clk) begin
    if (reset_n && in_valid && in_ready) xfers <= xfers + 1;
    if (reset_n && mac_valid) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_batch(input vec_t ta, input vec_t tb, input vec_t tc, input int toggle,
                           input int keepv, input int mode, input int lat, input int hold);
    logic [31:0]   ea, eb, ec;
    logic [RW-1:0] exp_data;
    logic          exp_err;
    int sum, x0, p0, g, cyc, exp_lat;
    ea = '0; eb = '0; ec = '0; sum = 0;
    for (int i = 0; i < 8; i++) begin
      ea = ea | (32'(ta[i]) << (4*i));
      eb = eb | (32'(tb[i]) << (4*i));
      ec = ec | (32'(tc[i]) << (4*i));
      sum += int'(ta[i]) * int'(tb[i]) + int'(tc[i]);
    end
    if (mode == 1) begin
      exp_lat = TIMEOUT + 1; exp_data = '0; exp_err = 1'b1;
    end else begin
      exp_lat = (mode == 2) ? 3 : lat + 2; exp_data = RW'(sum); exp_err = 1'b0;
    end
    stub_mode = mode;
    stub_lat  = lat;
    x0 = xfers;
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      if (toggle != 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_a = ta[i]; in_b = tb[i]; in_c = tc[i];
      g = 0;
      while (!in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) chk("fill_ready_timeout", 64'(g), 64'(0));
    end
    @(negedge clk);
    in_valid = (keepv != 0);
    chk("fire_mac_valid", mac_valid, 1);
    chk("fire_in_ready", in_ready, 0);
    chk("fire_mac_a", mac_a, ea);
    chk("fire_mac_b", mac_b, eb);
    chk("fire_mac_c", mac_c, ec);
    chk("fill_xfers", 64'(xfers - x0), 64'(8));
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (keepv != 0) begin
        in_a = 4'($urandom); in_b = 4'($urandom); in_c = 4'($urandom);
      end
    end
    chk("result_latency", 64'(cyc), 64'(exp_lat));
    chk("result_data", res_data, exp_data);
    chk("result_err", res_err, exp_err);
    chk("hold_in_ready", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp_data);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_res_valid", res_valid, 0);
    chk("post_res_err", res_err, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_xfers", 64'(xfers - x0), 64'(8));
    chk("post_pulses", 64'(pulses - p0), 64'(1));
    chk("post_mac_a_held", mac_a, ea);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t va, vb, vc;
    reset_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    chk("rst_mac_c", mac_c, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin va[i] = 4'd8; vb[i] = 4'd8; vc[i] = 4'd8; end
    run_batch(va, vb, vc, 0, 0, 0, 3, 0);

    for (int i = 0; i < 8; i++) begin va[i] = 4'(i); vb[i] = 4'(i + 1); vc[i] = 4'd1; end
    run_batch(va, vb, vc, 0, 0, 0, 4, 0);

    for (int i = 0; i < 8; i++) begin
      va[i] = 4'($urandom); vb[i] = 4'($urandom); vc[i] = 4'($urandom);
    end
    run_batch(va, vb, vc, 1, 0, 0, 2, 5);

    for (int i = 0; i < 8; i++) begin va[i] = 4'(i); vb[i] = 4'(15 - i); vc[i] = 4'(i); end
    run_batch(va, vb, vc, 0, 0, 1, 0, 1);

    stub_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 4'd5; in_b = 4'd5; in_c = 4'd5;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_mac_valid", mac_valid, 0);
    chk("midrst_mac_a", mac_a, 0);
    chk("midrst_res_valid", res_valid, 0);
    for (int i = 0; i < 8; i++) begin va[i] = 4'd3; vb[i] = 4'd3; vc[i] = 4'd3; end
    run_batch(va, vb, vc, 0, 0, 0, 3, 0);

    for (int i = 0; i < 8; i++) begin
      va[i] = 4'($urandom); vb[i] = 4'($urandom); vc[i] = 4'($urandom);
    end
    run_batch(va, vb, vc, 0, 1, 2, 0, 2);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) begin
        va[i] = 4'($urandom); vb[i] = 4'($urandom); vc[i] = 4'($urandom);
      end
      run_batch(va, vb, vc, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0,
                int'($urandom_range(1, 10)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
